// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width, control FSM states and the
// bundle of pipeline latch controls produced by the hazard/stall unit.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  // Order matches the bench-visible packing {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctl_t CTL_ADVANCE = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctl_t CTL_BRANCH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctl_t CTL_LOADUSE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctl_t CTL_IMISS   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctl_t CTL_DRAIN   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds an
// operand of the instruction sitting in ID. Register 0 never creates a hazard.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_memread,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     lu_hazard
);

  // Purely combinational compare of the load destination against both ID sources
  always_comb begin
    lu_hazard = idex_memread && (idex_rt != 5'd0) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller. Latch enables and flushes are decoded
// combinationally from the FSM state and the current hazard inputs; the FSM
// tracks data-memory waits, halt draining and the sticky halted condition,
// and a saturating counter records fetch-stall cycles.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dmem_req,
  input  logic             dhit,
  input  logic             idex_memread,
  input  regbits_t         idex_rt,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             branch_taken,
  input  logic             halt_ex,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_t state;
  pipe_ctl_t   ctl;
  logic        mem_stall;
  logic        lu_hazard;

  hazard_detect u_hazard_detect (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .lu_hazard    (lu_hazard)
  );

  assign mem_stall = dmem_req && !dhit;

  // Same-cycle control decode: reset freezes everything, memory stalls beat branches beat load-use beat fetch misses
  always_comb begin
    ctl = CTL_FREEZE;
    if (nRST) begin
      case (state)
        RUN, DWAIT: begin
          if (mem_stall)         ctl = CTL_FREEZE;
          else if (branch_taken) ctl = CTL_BRANCH;
          else if (lu_hazard)    ctl = CTL_LOADUSE;
          else if (!ihit)        ctl = CTL_IMISS;
          else                   ctl = CTL_ADVANCE;
        end
        DRAIN: begin
          if (mem_stall) ctl = CTL_FREEZE;
          else           ctl = CTL_DRAIN;
        end
        HALTED:  ctl = CTL_FREEZE;
        default: ctl = CTL_FREEZE;
      endcase
    end
  end

  assign pc_en      = ctl.pc_en;
  assign ifid_en    = ctl.ifid_en;
  assign idex_en    = ctl.idex_en;
  assign exmem_en   = ctl.exmem_en;
  assign memwb_en   = ctl.memwb_en;
  assign ifid_flush = ctl.ifid_flush;
  assign idex_flush = ctl.idex_flush;

  // Control FSM with registered halt flag and saturating stall counter; halt_ex waits out any memory stall
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= RUN;
      halt         <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (((state == RUN) || (state == DWAIT)) && !ctl.pc_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      case (state)
        RUN, DWAIT: begin
          if (mem_stall)    state <= DWAIT;
          else if (halt_ex) state <= DRAIN;
          else              state <= RUN;
        end
        DRAIN: begin
          if (halt_wb) begin
            state <= HALTED;
            halt  <= 1'b1;
          end
        end
        HALTED: begin
          halt <= 1'b1;
        end
        default: begin
          state <= RUN;
          halt  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl. Two instances share the
// stimulus: the default-width one and a CNT_W=4 one for counter saturation.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       nRST;
  logic       ihit, dmem_req, dhit, idex_memread;
  regbits_t   idex_rt, ifid_rs, ifid_rt;
  logic       branch_taken, halt_ex, halt_wb;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt;
  logic [15:0] stall_cycles;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_halt;
  logic [3:0]  s_stall_cycles;

  int testCount = 0;
  int failCount = 0;

  // Control vectors {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [6:0] V_ZERO = 7'b0000000;
  localparam logic [6:0] V_NORM = 7'b1111100;
  localparam logic [6:0] V_LU   = 7'b0011101;
  localparam logic [6:0] V_IMIS = 7'b0111110;
  localparam logic [6:0] V_BR   = 7'b1111111;
  localparam logic [6:0] V_DRN  = 7'b0111111;

  pipeline_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .halt_ex(halt_ex), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halt(halt), .stall_cycles(stall_cycles)
  );

  pipeline_ctrl #(.CNT_W(4)) dut_small (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .halt_ex(halt_ex), .halt_wb(halt_wb),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .halt(s_halt), .stall_cycles(s_stall_cycles)
  );

  // Free-running clock, 10 time units per period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic ih, input logic dreq, input logic dh,
                               input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                               input logic [4:0] rt2, input logic br, input logic hex,
                               input logic hwb);
    ihit = ih; dmem_req = dreq; dhit = dh; idex_memread = mr;
    idex_rt = rt; ifid_rs = rs; ifid_rt = rt2;
    branch_taken = br; halt_ex = hex; halt_wb = hwb;
    #2;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] expCtl);
    logic [6:0] obs;
    obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
    testCount++;
    assert (obs === expCtl) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expCtl);
    end
  endtask

  task automatic checkValue(input string tag, input int obs, input int expVal);
    testCount++;
    assert (obs === expVal) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expVal);
    end
  endtask

  // Linear sequence of directed steps with hand-computed expectations
  initial begin
    nRST = 1'b0;
    applyIdle();
    checkOutput("reset_comb_idle", V_ZERO);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_comb_branch", V_ZERO);
    checkValue("reset_stall", int'(stall_cycles), 0);
    checkValue("reset_halt", int'(halt), 0);
    checkValue("reset_state", int'(dut.state), int'(RUN));

    nRST = 1'b1;
    applyIdle();
    checkOutput("normal", V_NORM);
    tick();
    checkValue("normal_stall", int'(stall_cycles), 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("loaduse_rs", V_LU);
    tick();
    checkValue("loaduse_rs_stall", int'(stall_cycles), 1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("loaduse_rt", V_LU);
    tick();
    checkValue("loaduse_rt_stall", int'(stall_cycles), 2);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("loaduse_r0", V_NORM);
    tick();
    checkValue("loaduse_r0_stall", int'(stall_cycles), 2);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0);
    checkOutput("no_memread", V_NORM);
    tick();

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("imiss", V_IMIS);
    tick();
    checkValue("imiss_stall", int'(stall_cycles), 3);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("branch_over_lu", V_BR);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_over_imiss", V_LU);
    tick();
    checkValue("branch_lu_stall", int'(stall_cycles), 4);

    // Three cycles of outstanding data access, the first also carrying a branch
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, (i == 0), 1'b0, 1'b0);
      checkOutput("dwait_freeze", V_ZERO);
      tick();
      checkValue("dwait_state", int'(dut.state), int'(DWAIT));
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("dwait_hit", V_NORM);
    tick();
    checkValue("dwait_exit_state", int'(dut.state), int'(RUN));
    checkValue("dwait_stall", int'(stall_cycles), 7);

    // halt_ex arriving during a memory stall must wait for the access
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("halt_defer_freeze", V_ZERO);
    tick();
    checkValue("halt_defer_state", int'(dut.state), int'(DWAIT));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("halt_ex_cycle", V_NORM);
    tick();
    checkValue("drain1_state", int'(dut.state), int'(DRAIN));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain1_ignores", V_DRN);
    tick();
    checkValue("drain2_state", int'(dut.state), int'(DRAIN));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain2", V_DRN);
    tick();
    checkValue("halted_state", int'(dut.state), int'(HALTED));
    checkValue("halted_flag", int'(halt), 1);
    checkValue("drain_stall", int'(stall_cycles), 8);
    applyIdle();
    checkOutput("halted_freeze", V_ZERO);
    tick();
    checkValue("halt_sticky", int'(halt), 1);

    nRST = 1'b0;
    applyIdle();
    checkOutput("halted_reset_comb", V_ZERO);
    tick();
    checkValue("halt_cleared", int'(halt), 0);
    checkValue("halt_reset_state", int'(dut.state), int'(RUN));
    checkValue("halt_reset_stall", int'(stall_cycles), 0);
    nRST = 1'b1;
    applyIdle();
    checkOutput("after_reset", V_NORM);

    // DRAIN still freezes on a memory stall
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_memstall", V_ZERO);
    tick();
    checkValue("drain_memstall_state", int'(dut.state), int'(DRAIN));
    checkValue("drain_memstall_stall", int'(stall_cycles), 0);

    // Reset mid-DRAIN, then enter DWAIT and reset again
    nRST = 1'b0;
    applyIdle();
    tick();
    checkValue("drain_abandon", int'(dut.state), int'(RUN));
    nRST = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkValue("dwait_enter", int'(dut.state), int'(DWAIT));
    nRST = 1'b0;
    applyIdle();
    tick();
    checkValue("dwait_abandon", int'(dut.state), int'(RUN));
    checkValue("dwait_abandon_stall", int'(stall_cycles), 0);
    nRST = 1'b1;

    // Twenty fetch-miss cycles: 4-bit counter pins at 15, 16-bit one keeps counting
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      if (i == 14) checkValue("sat_small_14", int'(s_stall_cycles), 14);
      if (i == 15) checkValue("sat_small_15", int'(s_stall_cycles), 15);
    end
    checkValue("sat_small_20", int'(s_stall_cycles), 15);
    checkValue("sat_big_20", int'(stall_cycles), 20);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
